// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage of a single-cycle MIPS datapath.
//
// Holds the PC and fetches one instruction per step over a req/ack handshake.
// It presents the instruction and its opcode, then computes the next PC from
// Jump/Branch/Zero during EXEC.
//
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a FETCH watchdog
// is built and an ERR state is added. The watchdog trips after TIMEOUT cycles
// without an ack.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   Jump, Branch      control-unit decode, sampled in EXEC
//   Zero              ALU zero flag, sampled in EXEC
//   ImemReq/ImemAddr  fetch request and address (address == PC)
//   ImemAck/ImemData  memory response strobe and instruction word
//   PC, PCPlus4       current program counter and PC + 4
//   Instr, Op         instruction register and its opcode field [31:26]
//   InstrValid        one-cycle pulse per fetched instruction (EXEC)
//   FetchErr          sticky fetch-timeout flag (0 without FETCH_TIMEOUT_EN)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Instr,
  output logic [5:0]  Op,
  output logic        InstrValid,
  output logic        FetchErr
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StFetch, StExec, StErr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;
`endif

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_pc_next;

`ifdef FETCH_TIMEOUT_EN
  // Watchdog holds the number of ack-less FETCH cycles already elapsed.
  // Seeing TIMEOUT-1 with no ack in the current cycle means this is cycle TIMEOUT.
  localparam logic [15:0] WdogLast = 16'(TIMEOUT - 1);
  logic [15:0] r_wdog;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wdog <= 16'd0;
    end else if (r_state != StFetch) begin
      r_wdog <= 16'd0;  // zero on every entry into FETCH
    end else if (!ImemAck) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  w_state_d = StFetch;
      StFetch: begin
        if (ImemAck) begin
          w_state_d = StExec;
`ifdef FETCH_TIMEOUT_EN
        end else if (r_wdog == WdogLast) begin
          w_state_d = StErr;
`endif
        end
      end
      StExec:  w_state_d = StFetch;
`ifdef FETCH_TIMEOUT_EN
      StErr:   w_state_d = StErr;
`endif
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ImemReq    = 1'b0;
    InstrValid = 1'b0;
    FetchErr   = 1'b0;
    unique case (r_state)
      StFetch: ImemReq    = 1'b1;
      StExec:  InstrValid = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      StErr:   FetchErr   = 1'b1;
`endif
      default: ;
    endcase
  end

  // Next-PC: jump beats taken branch beats sequential; all arithmetic wraps.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (Jump) begin
      w_pc_next = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (Branch && Zero) begin
      w_pc_next = w_pc_plus4 + w_br_off;
    end
  end

  // PC and instruction register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
    end else begin
      if (r_state == StFetch && ImemAck) begin
        r_instr <= ImemData;
      end
      if (r_state == StExec) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign PC       = r_pc;
  assign ImemAddr = r_pc;
  assign PCPlus4  = w_pc_plus4;
  assign Instr    = r_instr;
  assign Op       = r_instr[31:26];

endmodule
